// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the operand-issue stage, the multicycle ALU
// and the result-writeback stage.
interface alu_multicycle_if #(
   parameter int WIDTH   = 128,
   parameter int SHAMT_W = $clog2(WIDTH)
) ();
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         opcode;
   logic [WIDTH-1:0]   input1;
   logic [WIDTH-1:0]   input2;
   logic [SHAMT_W-1:0] shift_value;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic               carry_flag;
   logic               zero_flag;
   logic               busy;

   modport master (
      output in_valid, opcode, input1, input2, shift_value, out_ready,
      input  in_ready, out_valid, result, carry_flag, zero_flag, busy
   );

   modport slave (
      input  in_valid, opcode, input1, input2, shift_value, out_ready,
      output in_ready, out_valid, result, carry_flag, zero_flag, busy
   );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops registered on accept, MUL on an iterative
// shift-add datapath taking WIDTH cycles.
module alu_multicycle #(
   parameter int WIDTH   = 128,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic             clk,
   input logic             rst,
   alu_multicycle_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_SLL   = 4'd4;
   localparam logic [3:0] OP_MUL   = 4'd5;
   localparam logic [3:0] OP_SEQ   = 4'd6;
   localparam logic [3:0] OP_SRL   = 4'd7;
   localparam logic [3:0] OP_PASSB = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_MUL_BUSY, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] alu_res_d;
   logic             alu_carry_d;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic             accept;

   // in_ready may only look at state and out_ready, never at in_valid.
   assign bus.in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.result     = result_q;
   assign bus.carry_flag = carry_q;
   assign bus.zero_flag  = (result_q == '0);

   // Bit WIDTH of the extended difference is the unsigned borrow.
   assign sum_w  = {1'b0, bus.input1} + {1'b0, bus.input2};
   assign diff_w = {1'b0, bus.input1} - {1'b0, bus.input2};
   assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      alu_res_d   = '0;
      alu_carry_d = 1'b0;
      case (bus.opcode)
         OP_ADD:   begin alu_res_d = sum_w[WIDTH-1:0];  alu_carry_d = sum_w[WIDTH];  end
         OP_SUB:   begin alu_res_d = diff_w[WIDTH-1:0]; alu_carry_d = diff_w[WIDTH]; end
         OP_AND:   alu_res_d = bus.input1 & bus.input2;
         OP_OR:    alu_res_d = bus.input1 | bus.input2;
         OP_SLL:   alu_res_d = bus.input1 << bus.shift_value;
         OP_SRL:   alu_res_d = bus.input1 >> bus.shift_value;
         OP_SEQ:   alu_res_d = {{(WIDTH-1){1'b0}}, (bus.input1 == bus.input2)};
         OP_PASSB: alu_res_d = bus.input2;
         default:  alu_res_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         result_q    <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_MUL_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q     <= S_DONE;
                  result_q    <= acc_d;
                  carry_q     <= 1'b0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            S_IDLE, S_DONE: begin
               if ((state_q == S_DONE) && bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
               // A request accepted on the consume edge overrides the return to IDLE.
               if (accept) begin
                  if (bus.opcode == OP_MUL) begin
                     state_q     <= S_MUL_BUSY;
                     busy_q      <= 1'b1;
                     out_valid_q <= 1'b0;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     mcand_q     <= bus.input1;
                     mplier_q    <= bus.input2;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= alu_res_d;
                     carry_q     <= alu_carry_d;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked successor to the generated single-cycle ALUs, sized by a `WIDTH` parameter with a fixed 128-bit default. It keeps the same opcode map, adds a registered result, zero and carry flags, and valid/ready flow control on both sides. MUL runs on an iterative shift-add datapath instead of a full-width combinational multiplier. It sits between an operand-issue stage and a result-writeback stage, and it supports back-pressure.

## Interface
- `WIDTH`, default 128: operand and result width; minimum 2.
- `SHAMT_W`, default `$clog2(WIDTH)`: shift-amount width.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: operation request present.
- `in_ready` output, 1: block can accept a request this cycle.
- `opcode` input, 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 MUL, 6 SEQ, 7 SRL, 8 PASSB; 9–15 are illegal.
- `input1`, `input2` input, WIDTH: operands.
- `shift_value` input, SHAMT_W: shift amount for SLL and SRL.
- `out_valid` output, 1: result and flags are valid.
- `out_ready` input, 1: consumer takes the result this cycle.
- `result` output, WIDTH: registered result.
- `carry_flag` output, 1: carry (ADD) or borrow (SUB); 0 for all other ops.
- `zero_flag` output, 1: set when `result` is all zeros.
- `busy` output, 1: high while an iterative MUL is in progress.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL_BUSY: `in_ready`=0, `busy`=1.
  - DONE: `out_valid`=1.
- Accept: happens on an edge where `in_valid && in_ready`. Operands, opcode and shift amount are captured at that edge and never sampled again.
- Non-MUL ops are computed in the accept cycle and registered. The state moves to DONE.
  - ADD: `result` = low WIDTH bits of `input1+input2`; `carry_flag` = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: `result` = `input1-input2` mod 2^WIDTH; `carry_flag` = 1 when `input1 < input2` (unsigned borrow).
  - AND, OR, PASSB (`result` = `input2`): bitwise as named; `carry_flag` = 0.
  - SLL/SRL: logical shift of `input1` by `shift_value`; zeros are filled in; `carry_flag` = 0.
  - SEQ: `result` = {WIDTH-1 zeros, (`input1==input2`)}; `carry_flag` = 0.
  - Illegal opcode: `result` = 0, `carry_flag` = 0, `zero_flag` = 1. A response is still produced (no hang).
- MUL: the accept edge moves the state to MUL_BUSY and clears the accumulator and the bit counter.
  - Each MUL_BUSY edge examines one multiplier bit, LSB first. If the bit is 1, the shifted multiplicand is added to the accumulator. The multiplicand then shifts left by 1, the multiplier shifts right by 1, and the counter increments.
  - After WIDTH iterations the state moves to DONE. `result` = low WIDTH bits of the unsigned product; `carry_flag` = 0.
- DONE: `result` and flags are held stable while `out_ready`=0.
  - When `out_ready`=1 the result is consumed. If `in_valid`=0 the state returns to IDLE.
  - In the same cycle, `in_ready` = `out_ready`. A new request can therefore be accepted on the consume edge (back-to-back issue) and the state goes straight to DONE or MUL_BUSY.
- `zero_flag` is derived from the registered `result` for every op.

## Timing
- Reset (any state, including mid-MUL): state = IDLE, `result` = 0, `carry_flag` = 0, `zero_flag` = 1.
  - `out_valid` = 0 and `busy` = 0; `in_ready` = 1 from the first cycle after reset.
  - Any in-flight MUL is discarded without a response.
- Non-MUL latency: accept on edge N, so `out_valid`=1 after edge N. The result is visible in the cycle after the request was presented.
- MUL latency: accept on edge N, MUL_BUSY through edges N+1..N+WIDTH, `out_valid`=1 after edge N+WIDTH. `busy` is high for cycles N+1..N+WIDTH.
- Throughput:
  - Non-MUL: 1 op per cycle when `out_ready` is held high.
  - MUL: 1 op per WIDTH+1 cycles.
- `in_ready` depends combinationally on state and `out_ready` only. `in_valid` has no combinational path to `in_ready`.
- Inputs presented while `in_ready`=0 are ignored. The requester must hold them until it is accepted.
- `out_valid`, once high, stays high with constant `result` and flags until the consume edge.

## Test plan
- Reset, then ADD `input1`=2^128-1, `input2`=1 -> after 1 cycle `result`=0, `carry_flag`=1, `zero_flag`=1, `out_valid`=1.
- SUB 5-7 (WIDTH=128) -> `result`=2^128-2, `carry_flag`=1; then SEQ with equal operands -> `result`=1, `zero_flag`=0.
- WIDTH=8, MUL 0x0F×0x11 -> `busy` high for 8 cycles, `out_valid` after edge N+8, `result`=0xFF. Then MUL 0xFF×0xFF -> `result`=0x01.
- Back-pressure: hold `out_ready`=0 for 5 cycles after an SLL of 1 by 127 -> `result`=2^127 stays stable and `in_ready`=0. Raise `out_ready` together with `in_valid` (SRL of 2^127 by 127) -> back-to-back accept, next `result`=1.
- Assert `rst` during cycle 3 of a MUL -> next cycle in IDLE: `out_valid`=0, `busy`=0, `result`=0, `zero_flag`=1. A following AND 0xF0&0x3C gives 0x30.
- Illegal opcode 12 -> `result`=0, `zero_flag`=1, `carry_flag`=0, handshake completes normally.
